// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth multiplier: one add/sub/no-op plus arithmetic shift per cycle,
// signed WIDTH x WIDTH -> 2*WIDTH product, start/busy/done handshake.
module booth_seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FINISH
  } state_t;

  state_t               state_q;
  logic [WIDTH:0]       a_q;
  logic [WIDTH:0]       m_q;
  logic [WIDTH-1:0]     q_q;
  logic                 q1_q;
  logic [CW-1:0]        count_q;
  logic                 busy_q;
  logic                 done_q;
  logic [2*WIDTH-1:0]   product_q;

  logic                 add_en;
  logic                 sub_en;
  logic [WIDTH:0]       addend;
  logic [WIDTH:0]       carry;
  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       a_d;
  logic [WIDTH-1:0]     q_d;
  logic                 q1_d;

  // Subtraction is A + ~M + 1; the +1 enters as the chain's carry-in.
  always_comb begin
    add_en = q_q[0] ^ q1_q;
    sub_en = q_q[0] & ~q1_q;
    addend = '0;
    if (add_en) begin
      addend = sub_en ? ~m_q : m_q;
    end
  end

  assign carry[0] = add_en & sub_en;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
    assign sum[i] = a_q[i] ^ addend[i] ^ carry[i];
    if (i < WIDTH) begin : g_carry
      assign carry[i+1] = (a_q[i] & addend[i]) | (carry[i] & (a_q[i] ^ addend[i]));
    end
  end

  // Arithmetic right shift of {A,Q,Q_1} with the fresh sum as A.
  assign a_d  = {sum[WIDTH], sum[WIDTH:1]};
  assign q_d  = {sum[0], q_q[WIDTH-1:1]};
  assign q1_d = q_q[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      m_q       <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= '0;
            q_q     <= multiplier;
            q1_q    <= 1'b0;
            m_q     <= {multiplicand[WIDTH-1], multiplicand};
            count_q <= CW'(WIDTH);
            busy_q  <= 1'b1;
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          a_q     <= a_d;
          q_q     <= q_d;
          q1_q    <= q1_d;
          count_q <= count_q - CW'(1);
          if (count_q == CW'(1)) begin
            state_q <= S_FINISH;
          end
        end
        S_FINISH: begin
          product_q <= {a_q[WIDTH-1:0], q_q};
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Self-checking bench: WIDTH=8 and WIDTH=16 instances, each compared every cycle against a
// timing/arithmetic model, plus directed vectors with hand-computed products.
module tb_booth_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  st = 2'b00;
  logic [15:0] mc [2];
  logic [15:0] mq [2];
  logic [1:0]  done_w;
  logic [1:0]  busy_w;
  logic [31:0] prod_w [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int W = (g == 0) ? 8 : 16;

    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    booth_seq_multiplier #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (st[g]),
      .multiplicand (mc[g][W-1:0]),
      .multiplier   (mq[g][W-1:0]),
      .busy         (busy),
      .done         (done),
      .product      (product)
    );

    assign done_w[g] = done;
    assign busy_w[g] = busy;
    assign prod_w[g] = 32'(product);

    // Model: accept when idle, done W+1 edges later, product = signed M*Q.
    int             cyc     = 0;
    int             done_at = -1;
    logic           e_busy  = 1'b0;
    logic           e_done  = 1'b0;
    logic [2*W-1:0] e_prod  = '0;
    logic [2*W-1:0] pend    = '0;

    always @(posedge clk) begin
      bit     idle;
      longint p;
      cyc++;
      if (rst) begin
        e_busy  = 1'b0;
        e_done  = 1'b0;
        e_prod  = '0;
        done_at = -1;
      end else begin
        idle   = (done_at < 0);
        e_done = (cyc == done_at);
        if (e_done) begin
          e_prod  = pend;
          e_busy  = 1'b0;
          done_at = -1;
        end
        if (idle && st[g]) begin
          p       = longint'($signed(mc[g][W-1:0])) * longint'($signed(mq[g][W-1:0]));
          pend    = p[2*W-1:0];
          done_at = cyc + W + 1;
          e_busy  = 1'b1;
        end
      end
    end

    always @(negedge clk) begin
      check($sformatf("w%0d_busy", W), longint'(busy), longint'(e_busy));
      check($sformatf("w%0d_done", W), longint'(done), longint'(e_done));
      check($sformatf("w%0d_product", W), longint'(product), longint'(e_prod));
      check($sformatf("w%0d_busy_done_overlap", W), longint'(busy & done), 0);
    end
  end

  task automatic wait_done(input int g, input int lim, output int n);
    n = 0;
    while (!done_w[g] && n < lim) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic op8(input logic [7:0] m, input logic [7:0] q, input logic [15:0] lit,
                     input string name);
    int n;
    @(negedge clk);
    mc[0] = {8'h00, m};
    mq[0] = {8'h00, q};
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    wait_done(0, 40, n);
    check({name, "_latency"}, n, 9);
    check(name, longint'(prod_w[0][15:0]), longint'(lit));
  endtask

  initial begin
    int n;
    int dcount;
    mc[0] = '0; mq[0] = '0; mc[1] = '0; mq[1] = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", longint'(busy_w[0]), 0);
    check("reset_product", longint'(prod_w[0]), 0);
    rst = 1'b0;

    op8(8'd7,   8'd3,   16'h0015, "m7_q3");
    op8(8'hFB,  8'd6,   16'hFFE2, "mn5_q6");
    op8(8'hFB,  8'hFA,  16'h001E, "mn5_qn6");
    op8(8'h80,  8'h80,  16'h4000, "mn128_qn128");
    op8(8'h80,  8'h7F,  16'hC080, "mn128_q127");
    op8(8'h00,  8'hFF,  16'h0000, "m0_qn1");
    op8(8'h7F,  8'h7F,  16'h3F01, "m127_q127");
    op8(8'hFF,  8'hFF,  16'h0001, "mn1_qn1");

    // Start pulsed mid-calculation with different operands must be ignored.
    @(negedge clk);
    mc[0] = 16'd7; mq[0] = 16'd3; st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (3) @(negedge clk);
    mc[0] = 16'd100; mq[0] = 16'd100; st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    wait_done(0, 40, n);
    check("ignore_midcalc_start", longint'(prod_w[0][15:0]), 16'h0015);

    // Start held high: second operation takes the operands present at its own accept edge.
    @(negedge clk);
    mc[0] = 16'd2; mq[0] = 16'd3; st[0] = 1'b1;
    @(negedge clk);
    mc[0] = 16'd5; mq[0] = 16'h00FC;
    wait_done(0, 40, n);
    check("held_first", longint'(prod_w[0][15:0]), 16'h0006);
    @(negedge clk);
    wait_done(0, 40, n);
    check("held_second_gap", n, 9);
    check("held_second", longint'(prod_w[0][15:0]), 16'hFFEC);
    st[0] = 1'b0;
    repeat (12) @(negedge clk);

    // Reset in the middle of a calculation aborts it.
    @(negedge clk);
    mc[0] = 16'd9; mq[0] = 16'd9; st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset_busy", longint'(busy_w[0]), 0);
    check("midreset_done", longint'(done_w[0]), 0);
    check("midreset_product", longint'(prod_w[0]), 0);
    rst = 1'b0;
    dcount = 0;
    repeat (15) begin
      @(negedge clk);
      if (done_w[0]) dcount++;
    end
    check("midreset_no_done", dcount, 0);

    for (int g = 0; g < 2; g++) begin
      int w;
      int iters;
      w     = (g == 0) ? 8 : 16;
      iters = (g == 0) ? 1500 : 800;
      for (int i = 0; i < iters; i++) begin
        @(negedge clk);
        mc[g] = 16'($urandom);
        mq[g] = 16'($urandom);
        st[g] = 1'b1;
        @(negedge clk);
        st[g] = 1'b0;
        wait_done(g, 50, n);
        check($sformatf("rand_w%0d_latency", w), n, w + 1);
      end
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

endmodule
